// File: rtl/serial_paralelo_lane.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_lane
// Description : Per-lane serial-to-parallel converter. Locks byte framing on a
//               run of COM symbols and packs the bytes that follow into
//               32-bit words. All-COM (idle) words are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo_lane #(
    parameter logic [7:0] COM       = 8'hBC,
    parameter int         ALIGN_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active
);

    localparam logic [3:0]  c_align_cnt = 4'(ALIGN_CNT);
    localparam logic [31:0] c_idle_word = {4{COM}};

    typedef enum logic [1:0] {
        ST_UNALIGNED = 2'd0,
        ST_ALIGNING  = 2'd1,
        ST_ACTIVE    = 2'd2
    } state_t;

    state_t      r_state, w_state;
    logic [7:0]  r_sr;
    logic [2:0]  r_bcnt, w_bcnt;
    logic [1:0]  r_wcnt, w_wcnt;
    logic [3:0]  r_ccnt, w_ccnt;
    logic [23:0] r_word, w_word;
    logic [31:0] w_data;
    logic        w_valid;
    logic        w_active;

    logic [7:0]  w_nxt;
    logic [31:0] w_full;

    assign w_nxt  = {r_sr[6:0], data_in};
    // Only the first three bytes need storage; the fourth is still in flight.
    assign w_full = {r_word, w_nxt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_UNALIGNED;
            r_sr      <= 8'd0;
            r_bcnt    <= 3'd0;
            r_wcnt    <= 2'd0;
            r_ccnt    <= 4'd0;
            r_word    <= 24'd0;
            data_out  <= 32'd0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_sr      <= w_nxt;
            r_bcnt    <= w_bcnt;
            r_wcnt    <= w_wcnt;
            r_ccnt    <= w_ccnt;
            r_word    <= w_word;
            data_out  <= w_data;
            valid_out <= w_valid;
            active    <= w_active;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_bcnt   = r_bcnt;
        w_wcnt   = r_wcnt;
        w_ccnt   = r_ccnt;
        w_word   = r_word;
        w_data   = data_out;
        w_valid  = 1'b0;
        w_active = active;

        case (r_state)
            ST_UNALIGNED: begin
                // Sliding search: any bit position may start a COM run.
                if (w_nxt == COM) begin
                    w_bcnt  = 3'd0;
                    w_ccnt  = 4'd1;
                    w_state = ST_ALIGNING;
                end
            end
            ST_ALIGNING: begin
                w_bcnt = r_bcnt + 3'd1;
                if (r_bcnt == 3'd7) begin
                    if (w_nxt == COM) begin
                        w_ccnt = r_ccnt + 4'd1;
                        if (r_ccnt + 4'd1 == c_align_cnt) begin
                            w_state  = ST_ACTIVE;
                            w_wcnt   = 2'd0;
                            w_active = 1'b1;
                        end
                    end else begin
                        w_state = ST_UNALIGNED;
                        w_ccnt  = 4'd0;
                    end
                end
            end
            ST_ACTIVE: begin
                w_bcnt = r_bcnt + 3'd1;
                if (r_bcnt == 3'd7) begin
                    w_wcnt = r_wcnt + 2'd1;
                    case (r_wcnt)
                        2'd0: w_word[23:16] = w_nxt;
                        2'd1: w_word[15:8]  = w_nxt;
                        2'd2: w_word[7:0]   = w_nxt;
                        default: begin
                            if (w_full != c_idle_word) begin
                                w_data  = w_full;
                                w_valid = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: w_state = ST_UNALIGNED;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo_lane.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_paralelo_lane
// Description : Self-checking bench: vector table, hand sequences and random
//               streams compared against a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo_lane;

    localparam logic [7:0] c_com   = 8'hBC;
    localparam int         c_align = 4;

    logic        clk;
    logic        reset;
    logic        data_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        active;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    serial_paralelo_lane #(
        .COM       (c_com),
        .ALIGN_CNT (c_align)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: works on the sliding 8-bit window and byte phase
    // relative to the COM that started the search, collecting bytes in a queue.
    int          m_mode;    // 0 searching, 1 counting COMs, 2 locked
    int          m_k;
    int          m_anchor;
    int          m_run;
    logic [7:0]  m_hist;
    logic [7:0]  m_q[$];
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_active;

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_anchor = 0; m_run = 0; m_hist = 8'd0;
        m_q.delete(); m_data = 32'd0; m_valid = 1'b0; m_active = 1'b0;
    endtask

    task automatic model_step(input logic b);
        logic [7:0]  byte8;
        logic [31:0] w;
        m_k++;
        byte8   = {m_hist[6:0], b};
        m_hist  = byte8;
        m_valid = 1'b0;
        if (m_mode == 0) begin
            if (byte8 == c_com) begin
                m_mode = 1; m_anchor = m_k; m_run = 1;
            end
        end else if ((m_k - m_anchor) % 8 == 0) begin
            if (m_mode == 1) begin
                if (byte8 == c_com) begin
                    m_run++;
                    if (m_run == c_align) begin
                        m_mode = 2; m_active = 1'b1; m_q.delete();
                    end
                end else begin
                    m_mode = 0;
                end
            end else begin
                m_q.push_back(byte8);
                if (m_q.size() == 4) begin
                    w = {m_q[0], m_q[1], m_q[2], m_q[3]};
                    if (w != {4{c_com}}) begin
                        m_data = w; m_valid = 1'b1;
                    end
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk);
        #1;
        model_step(b);
        if (valid_out === 1'b1) pulses++;
        chk("model_valid",  {31'd0, valid_out}, {31'd0, m_valid});
        chk("model_active", {31'd0, active},    {31'd0, m_active});
        chk("model_data",   data_out,           m_data);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) send_bit(v[i]);
    endtask

    // Asserted mid-cycle so the clear is seen before any clock edge.
    task automatic do_reset();
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_data",   data_out,            32'd0);
        chk("rst_async_valid",  {31'd0, valid_out},  32'd0);
        chk("rst_async_active", {31'd0, active},     32'd0);
        for (int i = 0; i < 3; i++) begin
            data_in = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_hold_data",   data_out,           32'd0);
            chk("rst_hold_valid",  {31'd0, valid_out}, 32'd0);
            chk("rst_hold_active", {31'd0, active},    32'd0);
        end
        reset = 1'b0;
        model_reset();
        pulses = 0;
    endtask

    // Aligns through c_align COMs, checking active rises on the very last bit.
    task automatic align_run();
        for (int n = 0; n < c_align - 1; n++) send_byte(c_com);
        for (int i = 7; i > 0; i--) send_bit(c_com[i]);
        chk("pre_align_active", {31'd0, active}, 32'd0);
        send_bit(c_com[0]);
        chk("align_active", {31'd0, active}, 32'd1);
    endtask

    typedef struct {
        int          nj;
        logic [2:0]  junk;
        logic [31:0] word;
        int          exp_pulses;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        reset   = 1'b0;
        data_in = 1'b0;
        model_reset();

        vecs[0] = '{0, 3'b000, 32'h12345678, 1, 32'h12345678};
        vecs[1] = '{3, 3'b101, 32'h12345678, 1, 32'h12345678};
        vecs[2] = '{0, 3'b000, 32'hBCBCBCBC, 0, 32'h00000000};
        vecs[3] = '{2, 3'b001, 32'h0000BC01, 1, 32'h0000BC01};
        vecs[4] = '{1, 3'b001, 32'hDEADBEEF, 1, 32'hDEADBEEF};
        vecs[5] = '{0, 3'b000, 32'hBCBCBC00, 1, 32'hBCBCBC00};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int j = vecs[v].nj - 1; j >= 0; j--) send_bit(vecs[v].junk[j]);
            align_run();
            send_word(vecs[v].word);
            chk("vec_pulses", 32'(pulses), 32'(vecs[v].exp_pulses));
            chk("vec_data",   data_out,    vecs[v].exp_data);
            send_byte(8'h00);
            chk("vec_no_extra_pulse", 32'(pulses), 32'(vecs[v].exp_pulses));
        end

        // Broken alignment: three COMs then a non-COM byte must not lock.
        do_reset();
        send_byte(c_com); send_byte(c_com); send_byte(c_com); send_byte(8'h00);
        chk("broken_active", {31'd0, active}, 32'd0);
        align_run();
        send_word(32'hDEADBEEF);
        chk("broken_pulses", 32'(pulses), 32'd1);
        chk("broken_data",   data_out,    32'hDEADBEEF);

        // Idle word suppression.
        do_reset();
        align_run();
        send_word(32'hA5A5A5A5);
        chk("idle_first_pulse", 32'(pulses), 32'd1);
        send_word(32'hBCBCBCBC);
        chk("idle_no_pulse", 32'(pulses), 32'd1);
        chk("idle_hold",     data_out,    32'hA5A5A5A5);
        send_word(32'h0000BC01);
        chk("idle_after_pulse", 32'(pulses), 32'd2);
        chk("idle_after_data",  data_out,    32'h0000BC01);

        // Reset in the 2nd byte of a word, then no output until realigned.
        do_reset();
        align_run();
        send_word(32'hCAFEF00D);
        send_byte(8'h11);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_byte(8'h22); send_word(32'h33445566); send_word(32'h778899AA);
        chk("midrst_no_pulse",  32'(pulses), 32'd0);
        chk("midrst_no_active", {31'd0, active}, 32'd0);
        align_run();
        send_word(32'h0BADBEEF);
        chk("midrst_realign_pulse", 32'(pulses), 32'd1);
        chk("midrst_realign_data",  data_out,    32'h0BADBEEF);

        // Random streams: random junk, COM runs of varying length, mixed words.
        for (int r = 0; r < 10; r++) begin
            do_reset();
            for (int i = $urandom_range(0, 20); i > 0; i--) send_bit(1'($urandom));
            for (int i = $urandom_range(2, 6); i > 0; i--) send_byte(c_com);
            for (int w = 0; w < 8; w++) begin
                case ($urandom_range(0, 3))
                    0: send_word({4{c_com}});
                    1: send_word({c_com, 8'($urandom), c_com, c_com});
                    default: send_word($urandom);
                endcase
            end
            if ($urandom_range(0, 1) == 1) send_bit(1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout: simulation exceeded time limit got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
